debug_uart_rx: RTL



---
 rtl/debug_uart_pkg.sv | 28 ++
 rtl/debug_rx_fifo.sv | 55 +++++
 rtl/debug_uart_rx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/debug_uart_pkg.sv
// Shared constants and types for the debug UART receiver: register offsets,
// STATUS bit positions, receive FSM states and divisor clamping.
package debug_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam logic [15:0] MIN_DIV = 16'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // The half-bit start delay is d>>1, so a divisor below 2 would never tick.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction

endpackage

// File: rtl/debug_rx_fifo.sv
// Byte FIFO with show-ahead read data. Pop is resolved before push, so a
// full FIFO accepts a push in the same cycle as a pop.
module debug_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        pop_ok, push_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/debug_uart_rx.sv
// Memory-mapped 8N1 receiver for the debug port: synchroniser, receive FSM,
// byte FIFO and a four-word register window.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | half a bit in, confirm the start bit (high = glitch)
//   DATA  | sample 8 data bits, LSB first, one per bit time
//   STOP  | sample stop bit: high pushes the byte, low flags a framing error
module debug_uart_rx
    import debug_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hf00000e0,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic        stb_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sync1_q, rxs_q, rxs_prev_q;
    rx_state_t     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   d_q, d_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [15:0]   div_q, div_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic [31:0]   data_q, data_d;
    logic          irq_q, irq_d;

    logic          tick, push_req, frame_set, overrun_set;
    logic          hit, rd, wr, pop_req, stat_clr;
    logic [1:0]    off;
    logic [7:0]    fifo_rdata;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count8;
    logic          unused_bits;

    assign unused_bits = ^{addr_i[1:0], data_i[31:16], we_i[3:2]};

    debug_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .wdata_i (shreg_q),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign count8 = 8'(fifo_count);

    // The counter is loaded with a bit time and the event fires on the cycle
    // it would reach zero, so the sampling period is exactly d clocks.
    assign tick = (cnt_q == 16'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    d_d     = div_q;
                    cnt_d   = div_q >> 1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rxs_q) begin
                        cnt_d   = d_q;
                        bit_d   = 3'd0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    cnt_d   = d_q;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    push_req  = rxs_q;
                    frame_set = !rxs_q;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hit      = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign off      = addr_i[3:2];
    assign rd       = stb_i && hit && (we_i == 4'b0000);
    assign wr       = stb_i && hit && (we_i != 4'b0000);
    assign pop_req  = rd && (off == REG_DATA) && !fifo_empty;
    assign stat_clr = wr && (off == REG_STATUS) && we_i[0];

    // A pop in the same cycle frees a slot, so only a push with no pop overruns.
    assign overrun_set = push_req && fifo_full && !pop_req;

    always_comb begin
        overrun_d   = overrun_set || (overrun_q && !(stat_clr && data_i[STAT_OVERRUN]));
        frame_err_d = frame_set || (frame_err_q && !(stat_clr && data_i[STAT_FRAME_ERR]));
        div_d       = div_q;
        if (wr && (off == REG_DIV) && (we_i[1:0] == 2'b11))
            div_d = clamp_div(data_i[15:0]);
        data_d = data_q;
        if (rd) begin
            case (off)
                REG_DATA:   data_d = fifo_empty ? 32'd0 : {24'd0, fifo_rdata};
                REG_STATUS: data_d = {16'd0, count8, 5'd0, frame_err_q, overrun_q, !fifo_empty};
                REG_DIV:    data_d = {16'd0, div_q};
                default:    data_d = 32'd0;
            endcase
        end
        irq_d = !fifo_empty;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            d_q         <= DEFAULT_DIV;
            bit_q       <= '0;
            shreg_q     <= '0;
            div_q       <= DEFAULT_DIV;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= rx_i;
            rxs_q       <= sync1_q;
            rxs_prev_q  <= rxs_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            div_q       <= div_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
            irq_q       <= irq_d;
        end
    end

    assign data_o = data_q;
    assign irq_o  = irq_q;

endmodule
